ic74192_driver: RTL and testbench

Synchronous command sequencer that drives the control pins of an IC74192 BCD up/down counter: master reset, parallel load, and counted UP/DN clock pulses. It is the driving end of the IC74192 pin interface. It accepts one command at a time over a valid/ready handshake and keeps a shadow copy of the count that the attached counter should hold. It also turns the counter's TCU/TCD terminal-count strobes into single-cycle carry/borrow events.

---
 rtl/ic74192_drv_pkg.sv | 31 +++
 rtl/ic74192_driver_sync2.sv | 28 ++
 rtl/ic74192_driver.sv | 214 +++++++++++++++++++++
 tb/tb_ic74192_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ic74192_drv_pkg.sv
// Shared encodings for the IC74192 command sequencer: opcodes, FSM states, BCD helpers.
// Optional compare monitor is enabled by defining MONITOR_EN (see ic74192_driver).
package ic74192_drv_pkg;

   typedef enum logic [1:0] {
      OP_CLEAR = 2'b00,
      OP_LOAD  = 2'b01,
      OP_UP    = 2'b10,
      OP_DOWN  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MR_HOLD = 3'd1,
      PL_HOLD = 3'd2,
      P_LOW   = 3'd3,
      P_HIGH  = 3'd4,
      FINISH  = 3'd5
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // One BCD count step, wrapping 9->0 upwards and 0->9 downwards.
   function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic up);
      logic [3:0] r;
      if (up) r = (q >= BCD_MAX) ? 4'd0 : 4'(q + 4'd1);
      else    r = (q == 4'd0) ? BCD_MAX : 4'(q - 4'd1);
      return r;
   endfunction

endpackage

// File: rtl/ic74192_driver_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous counter pins.
// Used for the terminal-count strobes and, with MONITOR_EN defined, for ic_q.
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p0 <= RST_VAL;
         sync_p1 <= RST_VAL;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/ic74192_driver.sv
// Command sequencer driving the MR/PL/UP/DN pins of an IC74192 BCD counter with a shadow count.
// Define MONITOR_EN to compare the synchronized counter outputs against the shadow count.
module ic74192_driver
   import ic74192_drv_pkg::*;
#(
   parameter int PULSE_W = 4,
   parameter int MR_W    = 2,
   parameter int PL_W    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_data,
   output logic       done,
   output logic       err,
   output logic [3:0] exp_q,
   output logic [3:0] ic_d,
   output logic       ic_up,
   output logic       ic_dn,
   output logic       ic_pl,
   output logic       ic_mr,
   input  logic [3:0] ic_q,
   input  logic       ic_tcu_n,
   input  logic       ic_tcd_n,
   output logic       carry,
   output logic       borrow,
   output logic       mismatch
);

   localparam logic [7:0] MR_LAST = 8'(MR_W - 1);
   localparam logic [7:0] PL_LAST = 8'(PL_W - 1);
   localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);

   state_e     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [3:0] npul, npul_nxt;
   logic       dir_up, dir_up_nxt;
   op_e        op_q, op_nxt;

   logic       accept;
   logic       load_ok;
   logic       load_bad;
   logic       step_now;

   logic       ic_up_nxt, ic_dn_nxt, ic_pl_nxt, ic_mr_nxt;
   logic       done_nxt, err_nxt, ready_nxt;
   logic [3:0] ic_d_nxt, exp_q_nxt;

   assign accept   = cmd_valid && cmd_ready;
   assign load_ok  = accept && (cmd_op == OP_LOAD) && (cmd_data <= BCD_MAX);
   assign load_bad = accept && (cmd_op == OP_LOAD) && (cmd_data > BCD_MAX);
   // The shadow count moves on the edge that starts the high phase of a pulse.
   assign step_now = (state == P_LOW) && (cnt == PW_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         npul   <= '0;
         dir_up <= 1'b1;
         op_q   <= OP_CLEAR;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         npul   <= npul_nxt;
         dir_up <= dir_up_nxt;
         op_q   <= op_nxt;
      end
   end

   // FINISH is the done cycle; it accepts a new command exactly like IDLE.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      npul_nxt   = npul;
      dir_up_nxt = dir_up;
      op_nxt     = op_q;
      case (state)
         IDLE, FINISH: begin
            state_nxt = IDLE;
            if (accept) begin
               cnt_nxt = '0;
               op_nxt  = op_e'(cmd_op);
               case (cmd_op)
                  OP_CLEAR: state_nxt = MR_HOLD;
                  OP_LOAD:  state_nxt = (cmd_data > BCD_MAX) ? FINISH : PL_HOLD;
                  default: begin
                     dir_up_nxt = (cmd_op == OP_UP);
                     npul_nxt   = cmd_data;
                     state_nxt  = (cmd_data == 4'd0) ? FINISH : P_LOW;
                  end
               endcase
            end
         end
         MR_HOLD: begin
            if (cnt == MR_LAST) state_nxt = FINISH;
            else                cnt_nxt   = cnt + 8'd1;
         end
         PL_HOLD: begin
            if (cnt == PL_LAST) state_nxt = FINISH;
            else                cnt_nxt   = cnt + 8'd1;
         end
         P_LOW: begin
            if (cnt == PW_LAST) begin
               state_nxt = P_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         P_HIGH: begin
            if (cnt == PW_LAST) begin
               cnt_nxt   = '0;
               npul_nxt  = 4'(npul - 4'd1);
               state_nxt = (npul == 4'd1) ? FINISH : P_LOW;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pin and status values for the next cycle, decoded from the next state.
   always_comb begin
      ic_up_nxt = !((state_nxt == P_LOW) && dir_up_nxt);
      ic_dn_nxt = !((state_nxt == P_LOW) && !dir_up_nxt);
      ic_mr_nxt = (state_nxt == MR_HOLD);
      ic_pl_nxt = (state_nxt != PL_HOLD);
      done_nxt  = (state_nxt == FINISH);
      err_nxt   = load_bad;
      ready_nxt = (state_nxt == IDLE) || (state_nxt == FINISH);
      ic_d_nxt  = load_ok ? cmd_data : ic_d;
      exp_q_nxt = exp_q;
      if (accept && (cmd_op == OP_CLEAR)) exp_q_nxt = 4'd0;
      else if (load_ok)                   exp_q_nxt = cmd_data;
      else if (step_now)                  exp_q_nxt = bcd_step(exp_q, dir_up);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ic_up     <= 1'b1;
         ic_dn     <= 1'b1;
         ic_pl     <= 1'b1;
         ic_mr     <= 1'b0;
         ic_d      <= 4'd0;
         exp_q     <= 4'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         ic_up     <= ic_up_nxt;
         ic_dn     <= ic_dn_nxt;
         ic_pl     <= ic_pl_nxt;
         ic_mr     <= ic_mr_nxt;
         ic_d      <= ic_d_nxt;
         exp_q     <= exp_q_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         cmd_ready <= ready_nxt;
      end
   end

   // Terminal-count strobes: sync, then flag each synchronized falling edge.
   logic [1:0] tc_sync_p1;
   logic [1:0] tc_prev_p2;

   sync2 #(.WIDTH(2), .RST_VAL(2'b11)) u_tc_sync (
      .clk (clk),
      .rst (rst),
      .d   ({ic_tcu_n, ic_tcd_n}),
      .q   (tc_sync_p1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tc_prev_p2 <= 2'b11;
         carry      <= 1'b0;
         borrow     <= 1'b0;
      end else begin
         tc_prev_p2 <= tc_sync_p1;
         carry      <= tc_prev_p2[1] && !tc_sync_p1[1];
         borrow     <= tc_prev_p2[0] && !tc_sync_p1[0];
      end
   end

`ifdef MONITOR_EN
   logic [3:0] q_sync_p1;
   logic       chk_now;

   sync2 #(.WIDTH(4), .RST_VAL(4'd0)) u_q_sync (
      .clk (clk),
      .rst (rst),
      .d   (ic_q),
      .q   (q_sync_p1)
   );

   assign chk_now = ((state == P_HIGH) && (cnt == PW_LAST)) ||
                    ((state == FINISH) && ((op_q == OP_CLEAR) || (op_q == OP_LOAD)));

   always_ff @(posedge clk) begin
      if (rst)                                  mismatch <= 1'b0;
      else if (accept && (cmd_op == OP_CLEAR))  mismatch <= 1'b0;
      else if (chk_now && (q_sync_p1 != exp_q)) mismatch <= 1'b1;
   end
`else
   logic unused_mon;
   assign unused_mon = ^{ic_q, op_q};
   assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_ic74192_driver.sv
// Directed bench for ic74192_driver with a behavioural IC74192 counter model on the pins.
// Define MONITOR_EN for both bench and design to exercise the compare monitor.
module tb_ic74192_driver;
   import ic74192_drv_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_data = 4'd0;
   logic       done, err;
   logic [3:0] exp_q, ic_d;
   logic       ic_up, ic_dn, ic_pl, ic_mr;
   logic [3:0] ic_q;
   logic       ic_tcu_n, ic_tcd_n;
   logic       carry, borrow, mismatch;

   int n_chk  = 0;
   int n_pass = 0;
   int n_carry  = 0;
   int n_borrow = 0;
   int c0, b0;

   always #5 clk = ~clk;

   ic74192_driver #(.PULSE_W(4), .MR_W(2), .PL_W(2)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .done(done), .err(err),
      .exp_q(exp_q), .ic_d(ic_d), .ic_up(ic_up), .ic_dn(ic_dn),
      .ic_pl(ic_pl), .ic_mr(ic_mr), .ic_q(ic_q), .ic_tcu_n(ic_tcu_n),
      .ic_tcd_n(ic_tcd_n), .carry(carry), .borrow(borrow), .mismatch(mismatch)
   );

   // Counter model: reacts mid-cycle to pin levels/rising edges; can be frozen.
   logic [3:0] mq = 4'd0;
   logic       stuck = 1'b0;
   logic       up_d = 1'b1, dn_d = 1'b1;

   always @(negedge clk) begin
      up_d <= ic_up;
      dn_d <= ic_dn;
      if (ic_mr === 1'b1)                             mq <= 4'd0;
      else if (ic_pl === 1'b0)                        mq <= ic_d;
      else if (!stuck && ic_up === 1'b1 && up_d === 1'b0) mq <= (mq == 4'd9) ? 4'd0 : mq + 4'd1;
      else if (!stuck && ic_dn === 1'b1 && dn_d === 1'b0) mq <= (mq == 4'd0) ? 4'd9 : mq - 4'd1;
   end

   assign ic_q     = mq;
   assign ic_tcu_n = !((mq == 4'd9) && (ic_up === 1'b0));
   assign ic_tcd_n = !((mq == 4'd0) && (ic_dn === 1'b0));

   always @(posedge clk) begin
      if (carry === 1'b1)  n_carry  <= n_carry + 1;
      if (borrow === 1'b1) n_borrow <= n_borrow + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_chk++;
      assert (got === want) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
   endtask

   // Offer one command and return in cycle 1 of it.
   task automatic send(input logic [1:0] op, input logic [3:0] d);
      int w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      chk("ready_wait", 8'(cmd_ready), 8'd1);
      cmd_op    = op;
      cmd_data  = d;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      // Reset for three cycles.
      tick();
      chk("rst_up", 8'(ic_up), 8'd1);
      chk("rst_dn", 8'(ic_dn), 8'd1);
      chk("rst_pl", 8'(ic_pl), 8'd1);
      chk("rst_mr", 8'(ic_mr), 8'd0);
      chk("rst_d", 8'(ic_d), 8'd0);
      chk("rst_expq", 8'(exp_q), 8'd0);
      chk("rst_done_err", 8'({done, err}), 8'd0);
      chk("rst_cb", 8'({carry, borrow}), 8'd0);
      chk("rst_mismatch", 8'(mismatch), 8'd0);
      chk("rst_ready", 8'(cmd_ready), 8'd0);
      tick(2);
      rst = 1'b0;
      chk("ready_at_release", 8'(cmd_ready), 8'd0);
      tick();
      chk("ready_after_release", 8'(cmd_ready), 8'd1);

      // CLEAR
      send(OP_CLEAR, 4'd0);
      chk("clr_mr_c1", 8'(ic_mr), 8'd1);
      chk("clr_expq_c1", 8'(exp_q), 8'd0);
      tick();
      chk("clr_mr_c2", 8'(ic_mr), 8'd1);
      chk("clr_done_c2", 8'(done), 8'd0);
      tick();
      chk("clr_mr_c3", 8'(ic_mr), 8'd0);
      chk("clr_done_c3", 8'(done), 8'd1);
      chk("clr_ready_c3", 8'(cmd_ready), 8'd1);
      chk("clr_mismatch", 8'(mismatch), 8'd0);

      // LOAD 9
      send(OP_LOAD, 4'd9);
      chk("ld9_pl_c1", 8'(ic_pl), 8'd0);
      chk("ld9_d_c1", 8'(ic_d), 8'd9);
      chk("ld9_expq_c1", 8'(exp_q), 8'd9);
      tick();
      chk("ld9_pl_c2", 8'(ic_pl), 8'd0);
      tick();
      chk("ld9_pl_c3", 8'(ic_pl), 8'd1);
      chk("ld9_done_err_c3", 8'({done, err}), 8'b10);
      chk("ld9_d_hold", 8'(ic_d), 8'd9);

      // UP n=2 from 9
      c0 = n_carry;
      send(OP_UP, 4'd2);
      chk("up_c1_pins", 8'({ic_up, ic_dn}), 8'b01);
      tick(3);
      chk("up_c4_up", 8'(ic_up), 8'd0);
      chk("up_c4_expq", 8'(exp_q), 8'd9);
      tick();
      chk("up_c5_up", 8'(ic_up), 8'd1);
      chk("up_c5_expq", 8'(exp_q), 8'd0);
      tick(3);
      chk("up_c8_done", 8'(done), 8'd0);
      tick();
      chk("up_c9_up", 8'(ic_up), 8'd0);
      tick(4);
      chk("up_c13_up", 8'(ic_up), 8'd1);
      chk("up_c13_expq", 8'(exp_q), 8'd1);
      tick(3);
      chk("up_c16_done", 8'(done), 8'd0);
      tick();
      chk("up_c17_done", 8'(done), 8'd1);
      chk("up_c17_pins", 8'({ic_up, ic_dn}), 8'b11);
      tick(4);
      chk("up_carry_once", 8'(n_carry - c0), 8'd1);

      // LOAD 0, DOWN n=1
      send(OP_LOAD, 4'd0);
      tick(2);
      chk("ld0_done", 8'(done), 8'd1);
      b0 = n_borrow;
      send(OP_DOWN, 4'd1);
      chk("dn_c1_pins", 8'({ic_up, ic_dn}), 8'b10);
      tick(3);
      chk("dn_c4_dn", 8'(ic_dn), 8'd0);
      tick();
      chk("dn_c5_dn", 8'(ic_dn), 8'd1);
      chk("dn_c5_expq", 8'(exp_q), 8'd9);
      tick(3);
      chk("dn_c8_done", 8'(done), 8'd0);
      tick();
      chk("dn_c9_done", 8'(done), 8'd1);
      tick(4);
      chk("dn_borrow_once", 8'(n_borrow - b0), 8'd1);

      // LOAD 12 rejected
      send(OP_LOAD, 4'd12);
      chk("ld12_done_err", 8'({done, err}), 8'b11);
      chk("ld12_pins", 8'({ic_pl, ic_mr, ic_up, ic_dn}), 8'b1011);
      chk("ld12_d", 8'(ic_d), 8'd0);
      chk("ld12_expq", 8'(exp_q), 8'd9);
      tick();
      chk("ld12_after", 8'({done, err}), 8'b00);
      chk("ld12_mismatch", 8'(mismatch), 8'd0);

      // Reset in cycle 6 of UP n=3
      send(OP_UP, 4'd3);
      tick(5);
      rst = 1'b1;
      tick();
      chk("rstmid_pins", 8'({ic_up, ic_dn, ic_pl, ic_mr}), 8'b1110);
      chk("rstmid_expq", 8'(exp_q), 8'd0);
      chk("rstmid_done", 8'(done), 8'd0);
      chk("rstmid_ready", 8'(cmd_ready), 8'd0);
      rst = 1'b0;
      tick();
      chk("rstmid_idle", 8'({cmd_ready, done}), 8'b10);
      tick(20);
      chk("rstmid_no_done", 8'({done, ic_up}), 8'b01);

`ifdef MONITOR_EN
      send(OP_CLEAR, 4'd0);
      tick(2);
      chk("mon_clr_done", 8'({done, mismatch}), 8'b10);
      stuck = 1'b1;
      send(OP_UP, 4'd1);
      tick(8);
      chk("mon_done", 8'(done), 8'd1);
      chk("mon_mismatch_set", 8'(mismatch), 8'd1);
      stuck = 1'b0;
      send(OP_CLEAR, 4'd0);
      chk("mon_mismatch_clr", 8'(mismatch), 8'd0);
      tick(3);
      chk("mon_mismatch_stays", 8'(mismatch), 8'd0);
`else
      send(OP_CLEAR, 4'd0);
      tick(2);
      chk("nomon_clr_done", 8'({done, mismatch}), 8'b10);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
